// File: rtl/reaction_timer_ctrl.sv
// Multi-player reaction timer: prescaled tick, LFSR fore-period, per-player latched times, winner and timeout.
// Optional macro REACT_FALSE_START_EN: stop edges during WAIT are recorded as false starts.
module reaction_timer_ctrl #(
    parameter int NUM_PLAYERS   = 2,
    parameter int TICK_DIV      = 50000,
    parameter int CNT_W         = 14,
    parameter int DELAY_MIN     = 1000,
    parameter int DELAY_RANGE_W = 11,
    localparam int WIN_W        = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_PLAYERS-1:0]       stop,
    output logic                         led,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_PLAYERS-1:0]       hit,
    output logic [NUM_PLAYERS-1:0]       false_start,
    output logic [NUM_PLAYERS*CNT_W-1:0] times,
    output logic [WIN_W-1:0]             winner,
    output logic                         winner_valid,
    output logic                         timeout
);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DLY_W = $clog2(DELAY_MIN + (1 << DELAY_RANGE_W) + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [DLY_W-1:0] DLY_BASE = DLY_W'(DELAY_MIN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ARMED = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   state_r;
    state_t                   next_state_s;
    logic                     start_q_r;
    logic [NUM_PLAYERS-1:0]   stop_q_r;
    logic [15:0]              lfsr_r;
    logic [PRE_W-1:0]         presc_r;
    logic [DLY_W-1:0]         delay_r;
    logic [CNT_W-1:0]         elapsed_r;
    logic                     start_edge_s;
    logic                     tick_s;
    logic                     sat_s;
    logic                     load_s;
    logic                     timeout_s;
    logic [NUM_PLAYERS-1:0]   stop_edge_s;
    logic [NUM_PLAYERS-1:0]   fs_edge_s;
    logic [NUM_PLAYERS-1:0]   arm_edge_s;
    logic [WIN_W-1:0]         first_idx_s;

    assign start_edge_s = start & ~start_q_r;
    assign stop_edge_s  = stop & ~stop_q_r;
    assign tick_s       = (presc_r == PRE_LAST);
    // The tick that brings elapsed to all-ones is the timeout event
    assign sat_s        = tick_s && (elapsed_r == (CNT_MAX - CNT_W'(1)));

    // Qualify stop edges by state and pick the lowest-index new hit
    always_comb begin
        arm_edge_s  = '0;
        fs_edge_s   = '0;
        first_idx_s = '0;
        if (state_r == S_ARMED) begin
            arm_edge_s = stop_edge_s & ~hit;
        end else begin
            arm_edge_s = '0;
        end
`ifdef REACT_FALSE_START_EN
        if (state_r == S_WAIT) begin
            fs_edge_s = stop_edge_s & ~hit;
        end else begin
            fs_edge_s = '0;
        end
`endif
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            first_idx_s = arm_edge_s[i] ? WIN_W'(i) : first_idx_s;
        end
    end

    // Next-state decision
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start_edge_s) begin
                    next_state_s = S_WAIT;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = state_r;
                end
            end
            S_WAIT: begin
                if (&(hit | fs_edge_s)) begin
                    next_state_s = S_DONE;
                end else if (tick_s && (delay_r <= DLY_W'(1))) begin
                    next_state_s = S_ARMED;
                end else begin
                    next_state_s = S_WAIT;
                end
            end
            S_ARMED: begin
                if (&(hit | arm_edge_s)) begin
                    next_state_s = S_DONE;
                end else if (sat_s) begin
                    next_state_s = S_DONE;
                    timeout_s    = 1'b1;
                end else begin
                    next_state_s = S_ARMED;
                end
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Input history, LFSR, timebase and status outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_q_r <= 1'b0;
            stop_q_r  <= '0;
            lfsr_r    <= 16'hACE1;
            presc_r   <= '0;
            led       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            start_q_r <= start;
            stop_q_r  <= stop;
            lfsr_r    <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
            if ((next_state_s != state_r) || tick_s) begin
                presc_r <= '0;
            end else begin
                presc_r <= presc_r + PRE_W'(1);
            end
            led  <= (next_state_s == S_ARMED);
            busy <= (next_state_s == S_WAIT) || (next_state_s == S_ARMED);
            done <= (next_state_s == S_DONE);
        end
    end

    // Fore-period, elapsed counter and per-player results
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            delay_r      <= '0;
            elapsed_r    <= '0;
            hit          <= '0;
            false_start  <= '0;
            times        <= '0;
            winner       <= '0;
            winner_valid <= 1'b0;
            timeout      <= 1'b0;
        end else if (load_s) begin
            delay_r      <= DLY_BASE + DLY_W'(lfsr_r[DELAY_RANGE_W-1:0]);
            elapsed_r    <= '0;
            hit          <= '0;
            false_start  <= '0;
            times        <= '0;
            winner       <= '0;
            winner_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            if ((state_r == S_WAIT) && tick_s && (delay_r != '0)) begin
                delay_r <= delay_r - DLY_W'(1);
            end
            if ((state_r == S_ARMED) && tick_s && (elapsed_r != CNT_MAX)) begin
                elapsed_r <= elapsed_r + CNT_W'(1);
            end
            hit         <= hit | fs_edge_s | arm_edge_s;
            false_start <= false_start | fs_edge_s;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (fs_edge_s[i]) begin
                    times[i*CNT_W +: CNT_W] <= CNT_MAX;
                end else if (arm_edge_s[i]) begin
                    times[i*CNT_W +: CNT_W] <= elapsed_r;
                end
            end
            if (!winner_valid && (|arm_edge_s)) begin
                winner       <= first_idx_s;
                winner_valid <= 1'b1;
            end
            if (timeout_s) begin
                timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Self-checking bench for reaction_timer_ctrl with small timing parameters and randomized stop timing.
module tb_reaction_timer_ctrl;
    localparam int NP   = 2;
    localparam int TD   = 4;
    localparam int CW   = 8;
    localparam int DMIN = 2;
    localparam int DRW  = 2;
    localparam int TOUT = TD * 255;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [NP-1:0] stop  = '0;
    logic          led, busy, done, winner_valid, timeout;
    logic [NP-1:0] hit, false_start;
    logic [NP*CW-1:0] times;
    logic [0:0]    winner;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [15:0] lfsr_m;

    reaction_timer_ctrl #(
        .NUM_PLAYERS(NP), .TICK_DIV(TD), .CNT_W(CW), .DELAY_MIN(DMIN), .DELAY_RANGE_W(DRW)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .led(led), .busy(busy), .done(done), .hit(hit), .false_start(false_start),
        .times(times), .winner(winner), .winner_valid(winner_valid), .timeout(timeout)
    );

    always #5 clock = ~clock;

    // Reference LFSR sequence: 16-bit Fibonacci, taps 16,14,13,11, seed ACE1
    always @(posedge clock or posedge reset) begin
        if (reset) lfsr_m <= 16'hACE1;
        else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    task automatic clk1;
        @(posedge clock);
        #1;
    endtask

    // Expected latched value for a stop driven c clocks after the lamp is seen
    function automatic logic [7:0] exp_time(input int c);
        int t;
        t = c / TD;
        if (t > 255) t = 255;
        return 8'(t);
    endfunction

    function automatic logic [0:0] exp_winner(input int o0, input int o1);
        if (o0 < 0) return 1'b1;
        if (o1 < 0) return 1'b0;
        return (o1 < o0) ? 1'b1 : 1'b0;
    endfunction

    // Pulse start, then wait for the lamp; reports what was seen
    task automatic press_start(output bit busy_ok, output bit cleared_ok, output bit armed_ok,
                               output int wait_clocks, output int delay_exp);
        delay_exp = DMIN + int'(lfsr_m[DRW-1:0]);
        start = 1'b1;
        clk1;
        busy_ok    = busy & ~led & ~done;
        cleared_ok = (hit == '0) && (times == '0) && !winner_valid && !timeout;
        start = 1'b0;
        wait_clocks = 0;
        armed_ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            clk1;
            wait_clocks++;
            if (led) begin
                armed_ok = 1'b1;
                break;
            end
        end
    endtask

    // From lamp-on, raise each stop at its offset (-1 = never) and wait for done
    task automatic drive_stops(input int off0, input int off1, output bit done_ok, output int done_c);
        done_ok = 1'b0;
        done_c  = 0;
        for (int c = 0; c < TOUT + 100; c++) begin
            if (c == off0) stop[0] = 1'b1;
            if (c == off1) stop[1] = 1'b1;
            clk1;
            if (done) begin
                done_ok = 1'b1;
                done_c  = c + 1;
                break;
            end
        end
        stop = '0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) clk1;
        chk_cnt++;
        if ({led, busy, done, winner_valid, timeout} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {led, busy, done, winner_valid, timeout});
        else pass_cnt++;
        chk_cnt++;
        if ({hit, false_start, times, winner} !== '0) $display("FAIL reset_results: got %h want 0", {hit, false_start, times, winner});
        else pass_cnt++;
        reset = 1'b0;
        clk1;
    endtask

    task automatic test_first_arm;
        bit b, cl, a;
        int w, d;
        for (int i = 0; i < 64 && lfsr_m[1:0] != 2'd1; i++) clk1;
        press_start(b, cl, a, w, d);
        chk_cnt++;
        if (b !== 1'b1) $display("FAIL first_busy: got %b want 1", b); else pass_cnt++;
        chk_cnt++;
        if (d !== 3) $display("FAIL first_delay_setup: got %0d want 3", d); else pass_cnt++;
        chk_cnt++;
        if (!a || w < 11 || w > 13) $display("FAIL first_led_latency: got %0d (armed %b) want 12", w, a);
        else pass_cnt++;
    endtask

    task automatic test_two_players;
        bit ok;
        int dc;
        drive_stops(36, 20, ok, dc);
        chk_cnt++;
        if (!ok || dc != 37) $display("FAIL two_done: got done %b at %0d want 1 at 37", ok, dc); else pass_cnt++;
        chk_cnt++;
        if (times !== {8'd5, 8'd9}) $display("FAIL two_times: got %h want 0509", times); else pass_cnt++;
        chk_cnt++;
        if ({winner, winner_valid, led, busy, hit, timeout} !== {1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0})
            $display("FAIL two_status: got w%b v%b led%b busy%b hit%b to%b want w1 v1 led0 busy0 hit11 to0",
                     winner, winner_valid, led, busy, hit, timeout);
        else pass_cnt++;
    endtask

    task automatic test_tie;
        bit b, cl, a, ok;
        int w, d, dc;
        press_start(b, cl, a, w, d);
        chk_cnt++;
        if (!b || !cl) $display("FAIL tie_restart: got busy %b cleared %b want 1 1", b, cl); else pass_cnt++;
        drive_stops(28, 28, ok, dc);
        chk_cnt++;
        if (!ok || times !== {8'd7, 8'd7} || winner !== 1'b0 || winner_valid !== 1'b1)
            $display("FAIL tie_result: got done%b times %h w%b v%b want 1 0707 0 1", ok, times, winner, winner_valid);
        else pass_cnt++;
    endtask

    task automatic test_timeout;
        bit b, cl, a, ok;
        int w, d, dc;
        press_start(b, cl, a, w, d);
        drive_stops(-1, -1, ok, dc);
        chk_cnt++;
        if (!ok || dc < TOUT - 1 || dc > TOUT + 1) $display("FAIL timeout_time: got done %b at %0d want 1 at %0d", ok, dc, TOUT);
        else pass_cnt++;
        chk_cnt++;
        if ({timeout, done, hit, winner_valid, times} !== {1'b1, 1'b1, 2'b00, 1'b0, 16'h0})
            $display("FAIL timeout_status: got to%b done%b hit%b v%b times %h want 1 1 00 0 0000",
                     timeout, done, hit, winner_valid, times);
        else pass_cnt++;
    endtask

    task automatic test_start_ignored;
        int d, w;
        bit a, ok;
        int dc;
        d = DMIN + int'(lfsr_m[DRW-1:0]);
        start = 1'b1; clk1; start = 1'b0; clk1; start = 1'b1; clk1; start = 1'b0;
        w = 2;
        a = 1'b0;
        for (int i = 0; i < 200; i++) begin
            clk1;
            w++;
            if (led) begin a = 1'b1; break; end
        end
        chk_cnt++;
        if (!a || w < 4 * d - 1 || w > 4 * d + 1) $display("FAIL start_in_wait: got led after %0d want %0d", w, 4 * d);
        else pass_cnt++;
        drive_stops(0, 0, ok, dc);
        chk_cnt++;
        if (!ok || times !== 16'h0000 || winner !== 1'b0) $display("FAIL zero_stop: got times %h w%b want 0000 0", times, winner);
        else pass_cnt++;
    endtask

    task automatic test_false_start;
        bit a, ok;
        int dc;
        start = 1'b1; clk1; start = 1'b0;
        stop[0] = 1'b1;
        clk1;
`ifdef REACT_FALSE_START_EN
        chk_cnt++;
        if (false_start !== 2'b01 || hit !== 2'b01 || times[7:0] !== 8'hFF || busy !== 1'b1 || led !== 1'b0)
            $display("FAIL fs_wait: got fs%b hit%b t0 %h busy%b led%b want 01 01 ff 1 0", false_start, hit, times[7:0], busy, led);
        else pass_cnt++;
        a = 1'b0;
        for (int i = 0; i < 200; i++) begin clk1; if (led) begin a = 1'b1; break; end end
        drive_stops(-1, 16, ok, dc);
        chk_cnt++;
        if (!a || !ok || times !== {8'd4, 8'hFF} || winner !== 1'b1 || winner_valid !== 1'b1 || false_start !== 2'b01)
            $display("FAIL fs_winner: got times %h w%b v%b fs%b want 04ff 1 1 01", times, winner, winner_valid, false_start);
        else pass_cnt++;
        start = 1'b1; clk1; start = 1'b0;
        stop = 2'b11;
        clk1;
        chk_cnt++;
        if ({done, led, winner_valid, false_start, times} !== {1'b1, 1'b0, 1'b0, 2'b11, 16'hFFFF})
            $display("FAIL fs_all: got done%b led%b v%b fs%b times %h want 1 0 0 11 ffff", done, led, winner_valid, false_start, times);
        else pass_cnt++;
        stop = '0;
        clk1;
`else
        chk_cnt++;
        if (false_start !== 2'b00 || hit !== 2'b00 || times !== 16'h0)
            $display("FAIL wait_stop_ignored: got fs%b hit%b times %h want 00 00 0000", false_start, hit, times);
        else pass_cnt++;
        stop = '0;
        a = 1'b0;
        for (int i = 0; i < 200; i++) begin clk1; if (led) begin a = 1'b1; break; end end
        drive_stops(12, 16, ok, dc);
        chk_cnt++;
        if (!a || !ok || times !== {8'd4, 8'd3} || winner !== 1'b0 || false_start !== 2'b00)
            $display("FAIL wait_then_arm: got times %h w%b fs%b want 0403 0 00", times, winner, false_start);
        else pass_cnt++;
`endif
    endtask

    task automatic test_reset_mid_armed;
        bit b, cl, a, ok;
        int w, d, dc;
        press_start(b, cl, a, w, d);
        for (int c = 0; c < 20; c++) begin
            if (c == 8) stop[0] = 1'b1;
            clk1;
        end
        chk_cnt++;
        if (hit !== 2'b01 || times[7:0] !== 8'd2) $display("FAIL pre_reset_hit: got hit%b t0 %h want 01 02", hit, times[7:0]);
        else pass_cnt++;
        reset = 1'b1;
        clk1;
        chk_cnt++;
        if ({led, busy, done, hit, times, winner_valid, winner} !== '0)
            $display("FAIL mid_reset: got led%b busy%b done%b hit%b times %h v%b want all 0", led, busy, done, hit, times, winner_valid);
        else pass_cnt++;
        reset = 1'b0;
        stop = '0;
        clk1;
        press_start(b, cl, a, w, d);
        drive_stops(4, 40, ok, dc);
        chk_cnt++;
        if (!a || !ok || times !== {8'd10, 8'd1} || winner !== 1'b0)
            $display("FAIL after_reset_run: got times %h w%b want 0a01 0", times, winner);
        else pass_cnt++;
    endtask

    task automatic test_random;
        bit b, cl, a, ok;
        int w, d, dc, o0, o1;
        logic [15:0] et;
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(0, 5)) clk1;
            press_start(b, cl, a, w, d);
            chk_cnt++;
            if (!b || !cl || !a || w < 4 * d - 1 || w > 4 * d + 1)
                $display("FAIL rnd_arm[%0d]: got busy%b clr%b wait %0d want 1 1 %0d", r, b, cl, w, 4 * d);
            else pass_cnt++;
            o0 = int'($urandom_range(0, 300));
            o1 = (r == 3) ? o0 : int'($urandom_range(0, 300));
            drive_stops(o0, o1, ok, dc);
            et = {exp_time(o1), exp_time(o0)};
            chk_cnt++;
            if (!ok || times !== et || winner !== exp_winner(o0, o1) || winner_valid !== 1'b1 || timeout !== 1'b0)
                $display("FAIL rnd_result[%0d]: got times %h w%b v%b to%b want %h %b 1 0 (offs %0d %0d)",
                         r, times, winner, winner_valid, timeout, et, exp_winner(o0, o1), o0, o1);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset;
        test_first_arm;
        test_two_players;
        test_tie;
        test_timeout;
        test_start_ignored;
        test_false_start;
        test_reset_mid_armed;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/reaction_timer_ctrl.md
Name: reaction_timer_ctrl

Overview:
Parametrised successor to the single-player reaction-time state machine. The block adds several things the single-player version lacks:
- a prescaled millisecond timebase;
- a pseudo-random fore-period before the stimulus;
- N player stop inputs, each with its own latched reaction time;
- winner arbitration and a timeout.

It sits between the debounced push-buttons and the BCD display / LED drivers.

Parameters:
NUM_PLAYERS, 2, number of stop inputs (1..8)
TICK_DIV, 50000, clock cycles per timebase tick (1 ms at 50 MHz); minimum 2
CNT_W, 14, width of each reaction-time counter in ticks
DELAY_MIN, 1000, minimum fore-period in ticks
DELAY_RANGE_W, 11, random fore-period extension: 0..2^DELAY_RANGE_W-1 ticks

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; returns block to IDLE
start  in  1  level from debounced button; rising edge is the event
stop  in  NUM_PLAYERS  per-player level; rising edge is the event
led  out  1  stimulus lamp, high only in ARMED
busy  out  1  high in WAIT or ARMED
done  out  1  high in DONE
hit  out  NUM_PLAYERS  player i has a latched result
false_start  out  NUM_PLAYERS  player i pressed before the stimulus
times  out  NUM_PLAYERS*CNT_W  packed results; player i at [i*CNT_W +: CNT_W]
winner  out  WIN_W  index of fastest valid player; WIN_W = max(1, clog2(NUM_PLAYERS))
winner_valid  out  1  at least one valid (non-false-start) result exists
timeout  out  1  elapsed counter saturated in ARMED

Behaviour:
- Reset value of every output and register is 0, except the LFSR, which resets to 16'hACE1. State resets to IDLE.
- Edge detect: start and stop are registered once. Event = current & ~previous. Response is visible one clock after the input rises.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clock in all states and is never zero.
- Prescaler: counts 0..TICK_DIV-1. tick is asserted for one clock at TICK_DIV-1. The prescaler is cleared on every state entry.
- States: IDLE, WAIT, ARMED, DONE. The state is 2 bits and has no spare state.
- IDLE:
  - all outputs 0;
  - start edge -> WAIT;
  - delay loaded = DELAY_MIN + lfsr[DELAY_RANGE_W-1:0];
  - hit, false_start, times, winner, winner_valid and timeout cleared.
- WAIT:
  - busy = 1;
  - delay decrements on each tick;
  - on the tick where delay = 1 -> ARMED, with led = 1 from the next clock;
  - a delay loaded as 0 behaves as 1.
- ARMED:
  - led = 1 and busy = 1;
  - elapsed counter starts at 0 and increments per tick, saturating at 2^CNT_W-1;
  - stop edge on player i with hit[i] = 0: times[i] <= elapsed and hit[i] <= 1 in the same clock;
  - further edges from that player are ignored;
  - simultaneous edges latch the same value for every player involved.
- Winner:
  - the first player latched is the winner;
  - if several players tie, the lowest index wins;
  - winner_valid is set with the first valid hit;
  - winner is never changed afterwards.
- ARMED -> DONE when all players have hit set, or when elapsed saturates (timeout <= 1). On timeout, players without a hit keep times = 0 and hit = 0.
- DONE:
  - done = 1, led = 0, busy = 0;
  - all results held;
  - start edge -> WAIT, with results cleared and a new delay loaded exactly as from IDLE.
- A start edge in WAIT or ARMED is ignored.
- Asynchronous reset in any state: immediate return to IDLE and all outputs 0, with no partial results retained.

Optional Feature:
REACT_FALSE_START_EN
- Defined:
  - a stop edge from player i during WAIT sets false_start[i] = 1, hit[i] = 1 and times[i] = all-ones;
  - player i is excluded from the winner;
  - if every player has false-started, WAIT -> DONE immediately, led never rises and winner_valid = 0.
- Undefined:
  - stop edges in WAIT are ignored;
  - false_start is tied to 0.

Test Plan:
Bench parameters: NUM_PLAYERS=2, TICK_DIV=4, CNT_W=8, DELAY_MIN=2, DELAY_RANGE_W=2.
1. Reset, start pulse with lfsr[1:0] = 1 -> busy is high one clock later; led rises after 3 ticks (12 clocks, ±1).
2. ARMED; stop[1] after 5 ticks, then stop[0] after 9 ticks -> times = {8'd5, 8'd9}, winner = 1, winner_valid = 1, done = 1, led = 0.
3. ARMED; both stops in the same clock at tick 7 -> both times = 7, winner = 0.
4. ARMED with no stops -> after 255 ticks: timeout = 1, done = 1, hit = 0, winner_valid = 0.
5. With REACT_FALSE_START_EN; stop[0] during WAIT -> false_start = 2'b01, times[0] = 8'hFF. Then stop[1] at tick 4 in ARMED -> winner = 1.
6. Assert reset mid-ARMED after one hit -> next clock: led = 0, hit = 0, times = 0, state is IDLE. A subsequent start runs normally.
